// File: rtl/cpu_mem_responder.sv
// Memory-side responder for the 8-bit single-cycle CPU: instruction/data memories plus a boot loader FSM.
// Optional upper-half data write protection is enabled with `define DMEM_WP_EN.
module cpu_mem_responder #(
  parameter int IM_AW = 8,
  parameter int DM_AW = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  PC,
  output logic [15:0] IR,
  input  logic [7:0]  Address_out,
  input  logic [7:0]  Data_out,
  input  logic        MW,
  output logic [7:0]  Data_in,
  input  logic        load_valid,
  input  logic [7:0]  load_data,
  output logic        load_ready,
  input  logic        reload,
  output logic        cpu_reset,
  output logic        running,
  output logic        wp_fault
);

  typedef enum logic [1:0] {CNT, HI, LO, RUN} state_t;

  state_t      r_state;
  logic [7:0]  r_word_cnt;
  logic [7:0]  r_idx;
  logic [7:0]  r_hi_byte;
  logic        r_running;
  logic        r_wp_fault;
  logic [15:0] r_imem [2**IM_AW];
  logic [7:0]  r_dmem [2**DM_AW];

  logic w_xfer;
  logic w_wp_hit;
  logic w_dmem_we;
  logic w_imem_we;
  logic w_hi_we;

  // r_running mirrors (state == RUN) so the CPU reset comes straight off a flop.
  assign load_ready = ~r_running;
  assign cpu_reset  = ~r_running;
  assign running    = r_running;
  assign w_xfer     = load_valid && load_ready;

`ifdef DMEM_WP_EN
  assign w_wp_hit = MW && r_running && Address_out[DM_AW-1];
  assign wp_fault = r_wp_fault;
`else
  assign w_wp_hit = 1'b0;
  assign wp_fault = 1'b0;
`endif

  assign w_dmem_we = MW && r_running && !w_wp_hit;
  assign w_imem_we = w_xfer && (r_state == LO);
  assign w_hi_we   = w_xfer && (r_state == HI);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= CNT;
      r_word_cnt <= 8'd0;
      r_idx      <= 8'd0;
      r_running  <= 1'b0;
      r_wp_fault <= 1'b0;
    end else begin
      case (r_state)
        CNT: if (w_xfer) begin
          r_word_cnt <= load_data;
          r_idx      <= 8'd0;
          if (load_data == 8'd0) begin
            r_state   <= RUN;
            r_running <= 1'b1;
          end else begin
            r_state <= HI;
          end
        end
        HI: if (w_xfer) r_state <= LO;
        LO: if (w_xfer) begin
          r_idx <= r_idx + 8'd1;
          if (r_idx + 8'd1 == r_word_cnt) begin
            r_state   <= RUN;
            r_running <= 1'b1;
          end else begin
            r_state <= HI;
          end
        end
        RUN: begin
          if (reload) begin
            r_state    <= CNT;
            r_running  <= 1'b0;
            r_wp_fault <= 1'b0;
          end else if (w_wp_hit) begin
            r_wp_fault <= 1'b1;
          end
        end
        default: begin
          r_state   <= CNT;
          r_running <= 1'b0;
        end
      endcase
    end
  end

  // Storage is never reset: a load aborted by reset leaves earlier words in place.
  always_ff @(posedge clk) begin
    if (w_hi_we)   r_hi_byte <= load_data;
    if (w_imem_we) r_imem[r_idx[IM_AW-1:0]] <= {r_hi_byte, load_data};
    if (w_dmem_we) r_dmem[Address_out[DM_AW-1:0]] <= Data_out;
  end

  assign IR      = (r_running && (PC < r_word_cnt)) ? r_imem[PC[IM_AW-1:0]] : 16'h0000;
  assign Data_in = r_dmem[Address_out[DM_AW-1:0]];

endmodule

// File: tb/tb_cpu_mem_responder.sv
// Directed bench for cpu_mem_responder: boot loading, fetch, data path, reload and async reset.
module tb_cpu_mem_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  PC;
  logic [15:0] IR;
  logic [7:0]  Address_out;
  logic [7:0]  Data_out;
  logic        MW;
  logic [7:0]  Data_in;
  logic        load_valid;
  logic [7:0]  load_data;
  logic        load_ready;
  logic        reload;
  logic        cpu_reset;
  logic        running;
  logic        wp_fault;

  int n_vec = 0;
  int n_err = 0;

  cpu_mem_responder #(.IM_AW(8), .DM_AW(8)) dut (
    .clk(clk), .reset(reset), .PC(PC), .IR(IR),
    .Address_out(Address_out), .Data_out(Data_out), .MW(MW), .Data_in(Data_in),
    .load_valid(load_valid), .load_data(load_data), .load_ready(load_ready),
    .reload(reload), .cpu_reset(cpu_reset), .running(running), .wp_fault(wp_fault)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One byte with valid held; caller decides whether valid drops afterwards.
  task automatic xfer(input logic [7:0] b, input string tag);
    load_data  = b;
    load_valid = 1'b1;
    chk(tag, {15'd0, load_ready}, 16'd1);
    tick();
  endtask

  task automatic do_reload();
    reload = 1'b1;
    tick();
    reload = 1'b0;
  endtask

  initial begin
    logic [7:0] prog3 [7];
    prog3 = '{8'h03, 8'hA1, 8'hB2, 8'hC3, 8'hD4, 8'hE5, 8'hF6};
    reset = 1'b1; PC = 8'd0; Address_out = 8'd0; Data_out = 8'd0; MW = 1'b0;
    load_valid = 1'b0; load_data = 8'd0; reload = 1'b0;
    #12;
    chk("rst_cpu_reset", {15'd0, cpu_reset}, 16'd1);
    chk("rst_running", {15'd0, running}, 16'd0);
    chk("rst_load_ready", {15'd0, load_ready}, 16'd1);
    chk("rst_IR", IR, 16'h0000);
    chk("rst_wp_fault", {15'd0, wp_fault}, 16'd0);
    reset = 1'b0;
    tick();

    // Boot 3 words, valid held high
    for (int i = 0; i < 7; i++) xfer(prog3[i], "boot3_ready");
    load_valid = 1'b0;
    chk("boot3_running", {15'd0, running}, 16'd1);
    chk("boot3_cpu_reset", {15'd0, cpu_reset}, 16'd0);
    chk("boot3_ready_low", {15'd0, load_ready}, 16'd0);
    PC = 8'd0; #1 chk("boot3_IR0", IR, 16'hA1B2);
    PC = 8'd1; #1 chk("boot3_IR1", IR, 16'hC3D4);
    PC = 8'd2; #1 chk("boot3_IR2", IR, 16'hE5F6);
    PC = 8'd3; #1 chk("boot3_IR3", IR, 16'h0000);
    PC = 8'd255; #1 chk("boot3_IR255", IR, 16'h0000);

    // Data path: store 11 then 5A to address 10
    MW = 1'b1; Address_out = 8'h10; Data_out = 8'h11;
    tick();
    Data_out = 8'h5A; #1;
    chk("dp_old_value", {8'd0, Data_in}, 16'h0011);
    tick();
    MW = 1'b0; #1;
    chk("dp_new_value", {8'd0, Data_in}, 16'h005A);

    // Lower-half boundary write always succeeds
    MW = 1'b1; Address_out = 8'h7F; Data_out = 8'h3C;
    tick();
    MW = 1'b0; #1;
    chk("dp_7F_write", {8'd0, Data_in}, 16'h003C);
    chk("dp_7F_no_fault", {15'd0, wp_fault}, 16'd0);

    // Upper-half write
    MW = 1'b1; Address_out = 8'h80; Data_out = 8'h77;
    tick();
    MW = 1'b0; #1;
`ifdef DMEM_WP_EN
    chk("wp_dropped", {15'd0, (Data_in !== 8'h77)}, 16'd1);
    chk("wp_fault_set", {15'd0, wp_fault}, 16'd1);
    tick(); tick();
    chk("wp_fault_sticky", {15'd0, wp_fault}, 16'd1);
    Address_out = 8'h7F; #1;
    chk("wp_upper_read_ok_7F", {8'd0, Data_in}, 16'h003C);
`else
    chk("nowp_80_write", {8'd0, Data_in}, 16'h0077);
    tick();
    chk("nowp_fault_zero", {15'd0, wp_fault}, 16'd0);
`endif

    // Reload from RUN
    do_reload();
    chk("reload_cpu_reset", {15'd0, cpu_reset}, 16'd1);
    chk("reload_ready", {15'd0, load_ready}, 16'd1);
    chk("reload_running", {15'd0, running}, 16'd0);
    chk("reload_wp_clear", {15'd0, wp_fault}, 16'd0);
    PC = 8'd0; #1 chk("reload_IR_zero", IR, 16'h0000);

    // MW while loading is ignored
    MW = 1'b1; Address_out = 8'h10; Data_out = 8'hEE;
    tick();
    MW = 1'b0; #1;
    chk("cnt_no_write", {8'd0, Data_in}, 16'h005A);

    // 1-word load
    xfer(8'h01, "w1_ready"); xfer(8'h12, "w1_ready"); xfer(8'h34, "w1_ready");
    load_valid = 1'b0;
    chk("w1_running", {15'd0, running}, 16'd1);
    PC = 8'd0; #1 chk("w1_IR0", IR, 16'h1234);
    PC = 8'd1; #1 chk("w1_IR1", IR, 16'h0000);

    // Backpressure: two idle cycles between bytes, garbage on load_data
    do_reload();
    for (int i = 0; i < 7; i++) begin
      xfer(prog3[i], "bp_ready");
      load_valid = 1'b0; load_data = 8'hFF;
      if (i < 6) begin
        chk("bp_not_running", {15'd0, running}, 16'd0);
        tick(); tick();
      end
    end
    chk("bp_running", {15'd0, running}, 16'd1);
    PC = 8'd0; #1 chk("bp_IR0", IR, 16'hA1B2);
    PC = 8'd1; #1 chk("bp_IR1", IR, 16'hC3D4);
    PC = 8'd2; #1 chk("bp_IR2", IR, 16'hE5F6);
    PC = 8'd3; #1 chk("bp_IR3", IR, 16'h0000);

    // Empty program
    do_reload();
    xfer(8'h00, "empty_ready");
    load_valid = 1'b0;
    chk("empty_running", {15'd0, running}, 16'd1);
    PC = 8'd0; #1 chk("empty_IR0", IR, 16'h0000);
    PC = 8'd2; #1 chk("empty_IR2", IR, 16'h0000);

    // reload outside RUN is ignored: stays loading after reload in CNT
    do_reload();
    reload = 1'b1; tick(); reload = 1'b0;
    xfer(8'h02, "mid_ready");
    load_valid = 1'b0;
    chk("mid_in_HI_ready", {15'd0, load_ready}, 16'd1);

    // Async reset while in HI, away from a clock edge
    #2 reset = 1'b1;
    #1;
    chk("async_cpu_reset", {15'd0, cpu_reset}, 16'd1);
    chk("async_running", {15'd0, running}, 16'd0);
    chk("async_ready", {15'd0, load_ready}, 16'd1);
    tick();
    reset = 1'b0;
    // After reset the FSM is in CNT: a zero count goes straight to RUN
    xfer(8'h00, "post_rst_ready");
    load_valid = 1'b0;
    chk("post_rst_running", {15'd0, running}, 16'd1);
    PC = 8'd0; #1 chk("post_rst_IR0", IR, 16'h0000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
